// File: rtl/alu_divrem_arbiter.sv
// alu_divrem_arbiter
// Two-requester round-robin front end for a single W0RM_ALU_DivRem unit.
// One operation is in flight at a time: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// Optional feature macro: DIVREM_ARB_DIV0_BYPASS_EN
//   When defined, DIV/REM with b == 0 is answered locally (IDLE -> RESP)
//   without touching the DivRem unit.
//
// Handshake: a request is taken on a rising edge when reqN_valid && reqN_ready.
// reqN_ready is only high in IDLE for the granted requester, so the
// requester must hold valid and its operands stable until it sees ready.
// rspN_valid is a single-cycle pulse; rsp_result/rsp_flags are valid with it
// and hold their value until the next capture.
module alu_divrem_arbiter #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [3:0]            req0_opcode,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [3:0]            req1_opcode,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,
    output logic                  rsp0_valid,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp_result,
    output logic [3:0]            rsp_flags,
    output logic                  div_data_valid,
    output logic [3:0]            div_opcode,
    output logic [DATA_WIDTH-1:0] div_data_a,
    output logic [DATA_WIDTH-1:0] div_data_b,
    input  logic [DATA_WIDTH-1:0] div_result,
    input  logic                  div_result_valid,
    input  logic [3:0]            div_result_flags,
    output logic                  busy,
    output logic [1:0]            fsm_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  last_grant;
    logic [3:0]            op_q;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic                  owner_q;

    logic                  grant0;
    logic                  grant1;
    logic                  accept;
    logic [3:0]            sel_op;
    logic [DATA_WIDTH-1:0] sel_a;
    logic [DATA_WIDTH-1:0] sel_b;
    logic                  bypass;

    // Grant: a lone valid wins; on a tie the requester opposite last_grant wins
    always_comb begin
        grant0 = req0_valid && (!req1_valid || last_grant);
        grant1 = req1_valid && (!req0_valid || !last_grant);
        accept = (state == S_IDLE) && (grant0 || grant1);
        sel_op = grant1 ? req1_opcode : req0_opcode;
        sel_a  = grant1 ? req1_a      : req0_a;
        sel_b  = grant1 ? req1_b      : req0_b;
    end

`ifdef DIVREM_ARB_DIV0_BYPASS_EN
    logic [DATA_WIDTH-1:0] byp_result;

    // Divide-by-zero answer computed locally: DIV gives all ones, REM gives a
    always_comb begin
        bypass     = (sel_b == '0) && ((sel_op == 4'd6) || (sel_op == 4'd7));
        byp_result = (sel_op == 4'd6) ? {DATA_WIDTH{1'b1}} : sel_a;
    end
`else
    // Divide-by-zero goes to the DivRem unit like any other operation
    always_comb begin
        bypass = 1'b0;
    end
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = bypass ? S_RESP : S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (div_result_valid) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Request capture and round-robin pointer update on accept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            owner_q    <= 1'b0;
            last_grant <= 1'b1;
        end else if (accept) begin
            op_q       <= sel_op;
            a_q        <= sel_a;
            b_q        <= sel_b;
            owner_q    <= grant1;
            last_grant <= grant1;
        end
    end

    // Response capture: only a result arriving in WAIT is taken
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_result <= '0;
            rsp_flags  <= '0;
        end else if ((state == S_WAIT) && div_result_valid) begin
            rsp_result <= div_result;
            rsp_flags  <= div_result_flags;
`ifdef DIVREM_ARB_DIV0_BYPASS_EN
        end else if (accept && bypass) begin
            rsp_result <= byp_result;
            rsp_flags  <= {2'b00, byp_result[DATA_WIDTH-1], (byp_result == '0)};
`endif
        end
    end

    // Outputs decoded from state and registered request
    always_comb begin
        req0_ready     = (state == S_IDLE) && grant0;
        req1_ready     = (state == S_IDLE) && grant1;
        div_data_valid = (state == S_ISSUE);
        rsp0_valid     = (state == S_RESP) && !owner_q;
        rsp1_valid     = (state == S_RESP) &&  owner_q;
        busy           = (state != S_IDLE);
        fsm_state      = state;
        div_opcode     = op_q;
        div_data_a     = a_q;
        div_data_b     = b_q;
    end

endmodule
